// File: rtl/jtag_master.sv
// JTAG host controller: turns reset / IR-scan / DR-scan / idle-clock commands into
// tck/tms/tdi sequences for an IEEE 1149.1 TAP and returns the captured tdo bits.
module jtag_master #(
  parameter int IR_LEN  = 3,
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] IR_LEN_W = 6'(IR_LEN);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [2:0] {RST_SEQ, IDLE, HEAD, SHIFT, TAIL, RUN} state_t;

  state_t           state_reg, state_next, seg_follow;
  logic [5:0]       cnt_reg, cnt_next, len_reg, len_next, seg_len, dr_len;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             tck_reg, tck_next, tms_reg, tms_next, tdi_reg, tdi_next;
  logic             last_reg, last_next, from_cmd_reg, from_cmd_next, tms_step;
  logic [1:0]       op_reg, op_next;
  logic [31:0]      data_reg, data_next, cap_reg, cap_next;
  logic [31:0]      rsp_data_reg, rsp_data_next;
  logic             rsp_valid_reg, rsp_valid_next;

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign tck       = tck_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;

  always_comb begin
    dr_len = cmd_len;
    if (cmd_len == 6'd0)
      dr_len = 6'd1;
    else if (cmd_len > 6'd32)
      dr_len = 6'd32;
  end

  // Length, tms value for the current step, and the segment that follows this one.
  // A segment that follows itself is the final one of its command.
  always_comb begin
    seg_len    = 6'd1;
    tms_step   = 1'b0;
    seg_follow = state_reg;
    case (state_reg)
      RST_SEQ: begin
        seg_len  = 6'd6;
        tms_step = (cnt_reg < 6'd5);
      end
      HEAD: begin
        seg_len    = (op_reg == OP_IR) ? 6'd4 : 6'd3;
        tms_step   = (cnt_reg < ((op_reg == OP_IR) ? 6'd2 : 6'd1));
        seg_follow = SHIFT;
      end
      SHIFT: begin
        seg_len    = len_reg;
        tms_step   = (cnt_reg == len_reg - 6'd1);
        seg_follow = TAIL;
      end
      TAIL: begin
        seg_len  = 6'd2;
        tms_step = (cnt_reg == 6'd0);
      end
      RUN: begin
        seg_len  = len_reg;
        tms_step = 1'b0;
      end
      default: begin
        seg_len    = 6'd1;
        tms_step   = 1'b0;
        seg_follow = state_reg;
      end
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    div_next       = div_reg;
    tck_next       = tck_reg;
    tms_next       = tms_reg;
    tdi_next       = tdi_reg;
    last_next      = last_reg;
    from_cmd_next  = from_cmd_reg;
    op_next        = op_reg;
    data_next      = data_reg;
    cap_next       = cap_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;

    if (state_reg == IDLE) begin
      if (cmd_valid) begin
        op_next       = cmd_op;
        data_next     = cmd_data;
        cap_next      = '0;
        cnt_next      = '0;
        div_next      = '0;
        last_next     = 1'b0;
        from_cmd_next = 1'b1;
        case (cmd_op)
          OP_RESET: state_next = RST_SEQ;
          OP_IR: begin
            state_next = HEAD;
            len_next   = IR_LEN_W;
          end
          OP_DR: begin
            state_next = HEAD;
            len_next   = dr_len;
          end
          default: begin
            state_next = RUN;
            len_next   = cmd_len;
            last_next  = (cmd_len == 6'd0);
          end
        endcase
      end
    end else if (div_reg != '0) begin
      div_next = div_reg - 1'b1;
    end else begin
      div_next = DIV_MAX;
      if (tck_reg) begin
        // Falling-edge slot: either start the next tck or, after the final high phase, finish.
        if (last_reg) begin
          state_next = IDLE;
          if (from_cmd_reg) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = (op_reg == OP_IR || op_reg == OP_DR) ? cap_reg : '0;
          end
        end else begin
          tck_next = 1'b0;
          tms_next = tms_step;
          tdi_next = (state_reg == SHIFT) ? data_reg[cnt_reg[4:0]] : 1'b1;
        end
      end else begin
        tck_next = 1'b1;
        if (state_reg == SHIFT)
          cap_next[cnt_reg[4:0]] = tdo;
        if (cnt_reg == seg_len - 6'd1) begin
          cnt_next   = '0;
          state_next = seg_follow;
          last_next  = (seg_follow == state_reg);
        end else begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RST_SEQ;
      cnt_reg       <= '0;
      len_reg       <= '0;
      div_reg       <= DIV_W'(1);  // first tck falls one edge after reset release
      tck_reg       <= 1'b1;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b1;
      last_reg      <= 1'b0;
      from_cmd_reg  <= 1'b0;
      op_reg        <= OP_RESET;
      data_reg      <= '0;
      cap_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      div_reg       <= div_next;
      tck_reg       <= tck_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
      last_reg      <= last_next;
      from_cmd_reg  <= from_cmd_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      cap_reg       <= cap_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP model on the JTAG pins, scoreboard queue
// filled by the command driver and drained by a response monitor.
module tb_jtag_master;
  localparam int IR_LEN  = 3;
  localparam int CLK_DIV = 2;
  localparam logic [31:0] DR_CAP = 32'hFFFFFAB1;
  localparam logic [2:0]  IR_CAP = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic        tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_master #(.IR_LEN(IR_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // TAP model
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t        tap_st = TLR;
  logic [31:0] dr_sr = 32'd0;
  logic [2:0]  ir_sr = 3'd0;
  logic [2:0]  ir_reg = 3'd0;
  int          tck_rises = 0;
  logic        tms_log [0:4095];
  logic        tdi_log [0:4095];

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tck_rises <= tck_rises + 1;
    tms_log[tck_rises & 4095] <= tms;
    tdi_log[tck_rises & 4095] <= tdi;
    case (tap_st)
      CDR:  dr_sr <= DR_CAP;
      SHDR: dr_sr <= {tdi, dr_sr[31:1]};
      CIR:  ir_sr <= IR_CAP;
      SHIR: ir_sr <= {tdi, ir_sr[2:1]};
      UIR:  ir_reg <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

  function automatic logic [63:0] pat(input int base, input int n, input bit use_tdi);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i] = use_tdi ? tdi_log[(base + i) & 4095] : tms_log[(base + i) & 4095];
    return pat_ret(r);
  endfunction

  function automatic logic [63:0] pat_ret(input logic [63:0] r);
    return r;
  endfunction

  // Acceptance bookkeeping for the monitor
  int cyc = 0, acc_cyc = 0, tck_at_acc = 0, rsp_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cyc    <= cyc;
      tck_at_acc <= tck_rises;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          ntck;
  } exp_t;
  exp_t sb_q[$];

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        rsp_count++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h, required no response", rsp_data);
        end else begin
          e = sb_q.pop_front();
          $display("rsp #%0d data=0x%08h tck=%0d edges=%0d", rsp_count, rsp_data,
                   tck_rises - tck_at_acc, cyc - 1 - acc_cyc);
          check("rsp_data", rsp_data, e.data);
          check("rsp_tck_count", tck_rises - tck_at_acc, e.ntck);
          check("rsp_edge", cyc - 1 - acc_cyc, 2 * e.ntck * CLK_DIV + 1);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                      input logic [31:0] exp_data, input int exp_tck, input bit expect_rsp,
                      input bit hold, input bit chk_b2b, output int base);
    int n;
    n = 0;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    base = tck_rises;
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 after %0d cycles, required 1", n);
      cmd_valid = 1'b0;
      return;
    end
    if (chk_b2b)
      check("accept_in_rsp_cycle", rsp_valid, 1'b1);
    if (expect_rsp)
      sb_q.push_back('{exp_data, exp_tck});
    @(negedge clk);
    if (!hold)
      cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 5000);
    check("done_ready", cmd_ready, 1'b1);
    check("tap_in_rti", tap_st, RTI);
  endtask

  task automatic do_reset();
    int k, base, rc;
    rc = rsp_count;
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_pins", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b111010);
    check("rst_rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    base = tck_rises;
    rst = 1'b0;
    k = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 500);
    $display("reset release: cmd_ready after %0d edges, tck=%0d", k, tck_rises - base);
    check("ready_edge", k, 12 * CLK_DIV + 1);
    check("rst_tck", tck_rises - base, 6);
    check("rst_tms", pat(base, 6, 1'b0), 64'h1F);
    check("rst_tap_rti", tap_st, RTI);
    check("rst_no_rsp", rsp_count, rc);
  endtask

  initial begin
    int b, b0, rc, n;
    do_reset();

    // IR scan 3'b010
    send(2'b01, 6'd0, 32'h2, 32'h1, 9, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("ir_tms", pat(b, 9, 1'b0), 64'h0C3);
    check("ir_tdi", pat(b + 4, 3, 1'b1), 64'h2);
    check("ir_update", ir_reg, 3'b010);

    // DR scan 32 bits
    send(2'b10, 6'd32, 32'h12345678, DR_CAP, 37, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("dr32_tms", pat(b, 37, 1'b0), 64'h1 | (64'h3 << 34));
    check("dr32_tdi", pat(b + 3, 32, 1'b1), 64'h12345678);
    check("dr32_tap_reg", dr_sr, 32'h12345678);

    // TAP reset command
    send(2'b00, 6'd9, 32'hFFFF, 32'h0, 6, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("treset_tms", pat(b, 6, 1'b0), 64'h1F);

    // DR length edges
    send(2'b10, 6'd0, 32'h0, 32'h1, 6, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("dr0_tms", pat(b, 6, 1'b0), 64'h19);
    send(2'b10, 6'd40, 32'hA5A50F0F, DR_CAP, 37, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("dr40_tap_reg", dr_sr, 32'hA5A50F0F);

    // Idle with zero length: no tck, response one edge after acceptance
    send(2'b11, 6'd0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, b);
    wait_done();
    check("idle0_tck", tck_rises - b, 0);

    // Back-to-back with cmd_valid held high
    send(2'b01, 6'd0, 32'h3, 32'h1, 9, 1'b1, 1'b1, 1'b0, b0);
    send(2'b10, 6'd32, 32'hCAFEF00D, DR_CAP, 37, 1'b1, 1'b1, 1'b1, b);
    send(2'b11, 6'd4, 32'hFFFFFFFF, 32'h0, 4, 1'b1, 1'b0, 1'b1, b);
    wait_done();
    check("b2b_total_tck", tck_rises - b0, 50);
    check("b2b_ir", ir_reg, 3'b011);
    check("b2b_dr", dr_sr, 32'hCAFEF00D);
    check("b2b_idle_tms", pat(b, 4, 1'b0), 64'h0);

    // Short DR scan leaves a nonzero rsp_data before the abort test
    send(2'b10, 6'd8, 32'h5A, 32'hB1, 13, 1'b1, 1'b0, 1'b0, b);
    wait_done();

    // Reset during SHIFT bit 10 of a DR scan
    send(2'b10, 6'd32, 32'h0F0F0F0F, 32'h0, 37, 1'b0, 1'b0, 1'b0, b);
    n = 0;
    while (!((tck_rises - b) >= 13 && !tck) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit10", tck_rises - b, 13);
    rc = rsp_count;
    do_reset();
    check("abort_no_rsp", rsp_count, rc);

    repeat (20) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jtag_master.md
# jtag_master

Clocked JTAG host controller that sequences the `tap` block through its IEEE 1149.1 state machine. It accepts IR-scan, DR-scan, TAP-reset and idle-clock commands over a valid/ready port. For each command it generates `tck`/`tms`/`tdi` and collects `tdo` into a response word. It replaces hand-written TMS/TDI sequencing in benches and is the on-chip bring-up/programming host for PRELOAD, EXTEST, INTEST, IDCODE, PROGRAM and BYPASS flows.

## Interface
- `IR_LEN`, 3: instruction register length, 1..32.
- `CLK_DIV`, 2: clk cycles per tck half-period, ≥1.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept; transfer when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks.
- `cmd_len` in 6: DR bit count, or idle tck count; ignored for IR scan and TAP reset.
- `cmd_data` in 32: shift-in data, LSB shifted first.
- `rsp_valid` out 1: one-cycle pulse when a command completes; no backpressure.
- `rsp_data` out 32: captured tdo bits; bit i is the i-th shifted bit; unused upper bits are 0.
- `busy` out 1: asserted whenever `cmd_ready`=0.
- `tck` out 1: JTAG clock.
- `tms` out 1: JTAG mode select.
- `tdi` out 1: JTAG data to TAP.
- `tdo` in 1: JTAG data from TAP.

## Operation
- States: RST_SEQ, IDLE, HEAD, SHIFT, TAIL, RUN.
- The TAP is assumed to be in Run-Test/Idle whenever the controller is in IDLE.
- Per-tck TMS sequences:
  - TAP reset: 1,1,1,1,1,0 (6 tck).
  - IR scan: HEAD 1,1,0,0; SHIFT IR_LEN bits with tms=0 except the last bit (1); TAIL 1,0. Total IR_LEN+6 tck.
  - DR scan: HEAD 1,0,0; SHIFT n bits, last bit with tms=1; TAIL 1,0. Total n+5 tck.
  - Idle clocks: n tck with tms=0.
- Length rules:
  - DR `cmd_len`=0 is treated as 1; values >32 are clamped to 32.
  - Idle with `cmd_len`=0 issues no tck; `rsp_valid` pulses on the cycle after acceptance.
- `tdi` carries `cmd_data[i]` during SHIFT bit i and is 1 at all other times.
- `tdo` is sampled only during SHIFT.
- `rsp_data` is 0 for the TAP reset and idle-clock commands.
- Reset:
  - On `rst`, the next edge forces `tck`=1, `tms`=1, `tdi`=1, `cmd_ready`=0, `busy`=1, `rsp_valid`=0, `rsp_data`=0.
  - Any command in progress is abandoned with no `rsp_valid`.
  - After `rst` deasserts, RST_SEQ runs the 6-tck TAP reset sequence automatically without pulsing `rsp_valid`, then enters IDLE.
- `cmd_ready`=1 only in IDLE. Commands offered while busy are ignored, not queued.

## Timing
- One tck period = 2·CLK_DIV clk cycles. Low phase comes first, high phase second; `tck` idles high.
- `tms` and `tdi` change only on the clk edge that drives `tck` low.
- `tdo` is registered on the clk edge that drives `tck` high.
- Acceptance edge = cycle 0. `tck` falls at edge 1 for the first period.
- For a command of N tck, `rsp_valid` is high in the cycle after edge 2·N·CLK_DIV+1. `cmd_ready` rises on that same edge.
- A command accepted during the `rsp_valid` cycle starts its first tck low on the next edge, so no extra tck is inserted between commands.
- `rsp_data` is valid while `rsp_valid`=1 and holds until the next command completes or `rst`.
- Post-reset: `cmd_ready` rises 12·CLK_DIV+1 edges after the first edge with `rst`=0.

## Test plan
- Reset, CLK_DIV=2, bench TAP model attached:
  - `tms` over 6 tck = 1,1,1,1,1,0.
  - `cmd_ready` rises 25 edges after reset release.
  - No `rsp_valid` pulse.
- IR scan, `cmd_data`=3'b010:
  - `tms` = 1,1,0,0,0,0,1,1,0 and SHIFT `tdi` = 0,1,0.
  - TAP capture value 3'b001 yields `rsp_data`=0x1.
  - `rsp_valid` at edge 37.
- DR scan, len 32, `cmd_data`=0x12345678, bench drives `tdo` from a 32-bit shift register preloaded with 0xFFFFFAB1:
  - `tdi` bits match 0x12345678 LSB first.
  - `rsp_data`=0xFFFFFAB1.
  - 37 tck issued.
- Back-to-back, `cmd_valid` held high:
  - Sequence: IR scan (0b011), then DR 32 bits, then idle 4 tck.
  - Each command is accepted in its predecessor's `rsp_valid` cycle.
  - `tck` is continuous with no gap.
  - Total 9+37+4 tck.
- Length edges:
  - DR `cmd_len`=0 gives 6 tck with 1 shifted bit.
  - DR `cmd_len`=40 gives 37 tck.
  - Idle `cmd_len`=0 gives 0 tck and `rsp_valid` at edge 1.
- Reset at SHIFT bit 10 of a DR scan:
  - Next edge: `tck`=`tms`=`tdi`=1, `cmd_ready`=0, `rsp_data`=0.
  - No `rsp_valid` for the aborted scan.
  - The 6-tck reset sequence then completes before `cmd_ready`=1.
